// File: rtl/delay_estimator.sv
// Peak-position delay estimator: measures where the correlation peak lands in each packet
// and tracks the delay fed to the downstream delay stage. Optional stats: DELAY_EST_STATS_EN.
module delay_estimator #(
    parameter int MAX_LEN_LOG2 = 10,
    parameter int WIDTH        = 16,
    parameter int AVG_LOG2     = 3,
    parameter int TOL          = 2,
    parameter int LOCK_CNT     = 4,
    parameter int JUMP         = 64,
    parameter int BAD_MAX      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [MAX_LEN_LOG2-1:0] target,
    input  logic [WIDTH-1:0]        i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    input  logic                    i_peak,
    output logic [WIDTH-1:0]        o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [MAX_LEN_LOG2-1:0] len,
    output logic                    len_valid,
`ifdef DELAY_EST_STATS_EN
    output logic [15:0]             miss_count,
    output logic [15:0]             reacq_count,
`endif
    output logic                    locked
);
    localparam int M      = MAX_LEN_LOG2;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(BAD_MAX + 1);

    typedef enum logic [0:0] {ST_ACQUIRE = 1'b0, ST_TRACK = 1'b1} state_t;

    state_t              state_r, state_nxt_s;
    logic [M-1:0]        idx_r, p_r, len_r, len_nxt_s;
    logic                seen_r, len_valid_r, len_valid_nxt_s, locked_r;
    logic [GOOD_W-1:0]   good_r, good_nxt_s;
    logic [BAD_W-1:0]    bad_r, bad_nxt_s, bad_inc_s;
    logic                beat_s, last_beat_s, seen_eff_s, rst_s, reacq_s, miss_s;
    logic [M-1:0]        p_eff_s, m_s, d_s, abs_d_s;
    logic signed [M-1:0] step_s;

    assign o_tdata  = i_tdata;
    assign o_tlast  = i_tlast;
    assign o_tvalid = i_tvalid;
    assign i_tready = o_tready;

    assign rst_s       = reset | clear;
    assign beat_s      = i_tvalid & o_tready;
    assign last_beat_s = beat_s & i_tlast;
    // A peak on the tlast beat itself still counts, using the live index.
    assign seen_eff_s  = seen_r | (beat_s & i_peak);
    assign p_eff_s     = seen_r ? p_r : idx_r;
    assign m_s         = target - p_eff_s;
    assign d_s         = m_s - len_r;
    assign abs_d_s     = d_s[M-1] ? ({M{1'b0}} - d_s) : d_s;
    assign step_s      = $signed(d_s) >>> AVG_LOG2;
    assign bad_inc_s   = bad_r + {{(BAD_W-1){1'b0}}, 1'b1};

    assign len       = len_r;
    assign len_valid = len_valid_r;
    assign locked    = locked_r;

    // Per-packet acquisition / tracking decision, evaluated on the tlast beat.
    always_comb begin
        state_nxt_s     = state_r;
        len_nxt_s       = len_r;
        len_valid_nxt_s = 1'b0;
        good_nxt_s      = good_r;
        bad_nxt_s       = bad_r;
        reacq_s         = 1'b0;
        miss_s          = 1'b0;
        if (last_beat_s) begin
            miss_s = ~seen_eff_s;
            case (state_r)
                ST_ACQUIRE: begin
                    if (seen_eff_s) begin
                        len_nxt_s       = m_s;
                        len_valid_nxt_s = 1'b1;
                        good_nxt_s      = {GOOD_W{1'b0}};
                        bad_nxt_s       = {BAD_W{1'b0}};
                        state_nxt_s     = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_ACQUIRE;
                    end
                end
                ST_TRACK: begin
                    if (seen_eff_s && (abs_d_s <= M'(JUMP))) begin
                        len_nxt_s       = len_r + $unsigned(step_s);
                        len_valid_nxt_s = 1'b1;
                        bad_nxt_s       = {BAD_W{1'b0}};
                        if (abs_d_s <= M'(TOL)) begin
                            good_nxt_s = (good_r == GOOD_W'(LOCK_CNT)) ? good_r
                                       : good_r + {{(GOOD_W-1){1'b0}}, 1'b1};
                        end else begin
                            good_nxt_s = {GOOD_W{1'b0}};
                        end
                    end else begin
                        good_nxt_s = {GOOD_W{1'b0}};
                        if (bad_inc_s >= BAD_W'(BAD_MAX)) begin
                            bad_nxt_s   = {BAD_W{1'b0}};
                            state_nxt_s = ST_ACQUIRE;
                            reacq_s     = 1'b1;
                        end else begin
                            bad_nxt_s = bad_inc_s;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_ACQUIRE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, measurement and output registers; only beats advance the packet state.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r     <= ST_ACQUIRE;
            idx_r       <= {M{1'b0}};
            p_r         <= {M{1'b0}};
            seen_r      <= 1'b0;
            len_r       <= {M{1'b0}};
            len_valid_r <= 1'b0;
            good_r      <= {GOOD_W{1'b0}};
            bad_r       <= {BAD_W{1'b0}};
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            len_r       <= len_nxt_s;
            len_valid_r <= len_valid_nxt_s;
            good_r      <= good_nxt_s;
            bad_r       <= bad_nxt_s;
            locked_r    <= (state_nxt_s == ST_TRACK) && (good_nxt_s == GOOD_W'(LOCK_CNT));
            if (last_beat_s) begin
                idx_r  <= {M{1'b0}};
                seen_r <= 1'b0;
            end else if (beat_s) begin
                idx_r <= (idx_r == {M{1'b1}}) ? idx_r : idx_r + {{(M-1){1'b0}}, 1'b1};
                if (i_peak && !seen_r) begin
                    p_r    <= idx_r;
                    seen_r <= 1'b1;
                end
            end
        end
    end

`ifdef DELAY_EST_STATS_EN
    logic [15:0] miss_count_r, reacq_count_r;
    assign miss_count  = miss_count_r;
    assign reacq_count = reacq_count_r;

    // Saturating diagnostics counters for missed peaks and lost locks.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            miss_count_r  <= 16'h0000;
            reacq_count_r <= 16'h0000;
        end else begin
            if (miss_s && (miss_count_r != 16'hFFFF)) miss_count_r <= miss_count_r + 16'h0001;
            if (reacq_s && (reacq_count_r != 16'hFFFF)) reacq_count_r <= reacq_count_r + 16'h0001;
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = reacq_s ^ miss_s;
`endif
endmodule
